duck_sprite_ctrl: RTL and testbench

Per-duck motion and animation controller feeding the color mapper. Tracks duck position, flight/shot/fall/escape behaviour, and animation frame, advancing once per video frame. Each pixel clock it converts the current DrawX/DrawY into the `is_duck` flag and the 16-bit `duck_addr` sprite-sheet address. It also reports hits and escapes to the game-state logic.

---
 rtl/duck_sprite_ctrl.sv | 261 ++++++++++++++++++++++++++
 tb/tb_duck_sprite_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/duck_sprite_ctrl.sv
// duck_sprite_ctrl
//   Per-duck motion/animation controller. Motion and animation step once per
//   video frame (rising edge of frame_clk); every Clk the current DrawX/DrawY
//   is turned into is_duck and a sprite-sheet address.
//
//   Optional feature macro: DUCK_ESCAPE_EN
//     defined   : after FLY_TICKS frame ticks in FLY the duck flies straight up
//                 and off screen, pulsing duck_escaped.
//     undefined : no fly timeout; the duck bounces in FLY until shot, and
//                 duck_escaped is held at 0.
//
//   Ports
//     Clk, Reset_n         : clock, async active-low reset
//     frame_clk            : vsync-derived level, rising edge = one frame tick
//     state[2:0]           : game state, active when 001/010/100
//     DrawX, DrawY         : current pixel coordinates
//     shot_valid, shot_x/y : one-cycle trigger pulse with its coordinates
//     is_duck              : registered, pixel inside the 64x64 sprite box
//     duck_addr            : registered, {frame[3:0], row[5:0], col[5:0]}
//     duck_hit             : one-cycle pulse, duck was shot
//     duck_escaped         : one-cycle pulse, duck left the screen
module duck_sprite_ctrl #(
  parameter int SPAWN_X    = 288,
  parameter int FLY_TICKS  = 600,
  parameter int SHOT_TICKS = 30
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        frame_clk,
  input  logic [2:0]  state,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic        shot_valid,
  input  logic [9:0]  shot_x,
  input  logic [9:0]  shot_y,
  output logic        is_duck,
  output logic [15:0] duck_addr,
  output logic        duck_hit,
  output logic        duck_escaped
);

  typedef enum logic [2:0] {
    S_IDLE, S_SPAWN, S_FLY, S_SHOT, S_FALL
`ifdef DUCK_ESCAPE_EN
    , S_ESCAPE
`endif
  } st_e;

  localparam logic [9:0] X_MAX   = 10'd576;
  localparam logic [9:0] Y_MAX   = 10'd416;
  localparam logic [9:0] SPAWN_Y = 10'd416;

  st_e         st_q, st_d;
  logic [9:0]  x_q, x_d, y_q, y_d;
  logic        vxn_q, vxn_d;       // 1: vx = -2, 0: vx = +2
  logic        vyn_q, vyn_d;       // 1: vy = -2, 0: vy = +2
  logic [1:0]  anim_q, anim_d;
  logic [2:0]  adiv_q, adiv_d;     // ticks since last anim step, 0..5
  logic [15:0] cnt_q, cnt_d;       // fly ticks in FLY, ticks in SHOT/FALL
  logic        hit_q, hit_d;
  logic [2:0]  fc_q;               // frame_clk sync (2 flops) + edge history
  logic        tick_q;
  logic        is_duck_q, is_duck_d;
  logic [15:0] addr_q, addr_d;
`ifdef DUCK_ESCAPE_EN
  logic        esc_q, esc_d;
`endif

  logic              active, hit_in, anim_step;
  logic signed [11:0] nx, ny;
  logic [10:0]       y4;
  logic [3:0]        frame;
  logic [9:0]        dx, dy;

  assign active = (state == 3'b001) || (state == 3'b010) || (state == 3'b100);

  // Inclusive 64x64 box test; 11-bit math so x+63 cannot wrap.
  assign hit_in = shot_valid &&
                  ({1'b0, shot_x} >= {1'b0, x_q}) && ({1'b0, shot_x} <= {1'b0, x_q} + 11'd63) &&
                  ({1'b0, shot_y} >= {1'b0, y_q}) && ({1'b0, shot_y} <= {1'b0, y_q} + 11'd63);

  always_comb begin
    nx = vxn_q ? ({2'b00, x_q} - 12'd2) : ({2'b00, x_q} + 12'd2);
    ny = vyn_q ? ({2'b00, y_q} - 12'd2) : ({2'b00, y_q} + 12'd2);
    y4 = {1'b0, y_q} + 11'd4;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      fc_q   <= '0;
      tick_q <= 1'b0;
    end else begin
      fc_q   <= {fc_q[1:0], frame_clk};
      tick_q <= fc_q[1] & ~fc_q[2];
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      st_q      <= S_IDLE;
      x_q       <= 10'(SPAWN_X);
      y_q       <= SPAWN_Y;
      vxn_q     <= 1'b0;
      vyn_q     <= 1'b1;
      anim_q    <= '0;
      adiv_q    <= '0;
      cnt_q     <= '0;
      hit_q     <= 1'b0;
      is_duck_q <= 1'b0;
      addr_q    <= '0;
`ifdef DUCK_ESCAPE_EN
      esc_q     <= 1'b0;
`endif
    end else begin
      st_q      <= st_d;
      x_q       <= x_d;
      y_q       <= y_d;
      vxn_q     <= vxn_d;
      vyn_q     <= vyn_d;
      anim_q    <= anim_d;
      adiv_q    <= adiv_d;
      cnt_q     <= cnt_d;
      hit_q     <= hit_d;
      is_duck_q <= is_duck_d;
      addr_q    <= addr_d;
`ifdef DUCK_ESCAPE_EN
      esc_q     <= esc_d;
`endif
    end
  end

  always_comb begin
    st_d      = st_q;
    x_d       = x_q;
    y_d       = y_q;
    vxn_d     = vxn_q;
    vyn_d     = vyn_q;
    anim_d    = anim_q;
    adiv_d    = adiv_q;
    cnt_d     = cnt_q;
    hit_d     = 1'b0;
    anim_step = 1'b0;
`ifdef DUCK_ESCAPE_EN
    esc_d     = 1'b0;
`endif

    case (st_q)
      S_IDLE: if (active) st_d = S_SPAWN;
      S_SPAWN: begin
        x_d    = 10'(SPAWN_X);
        y_d    = SPAWN_Y;
        vxn_d  = 1'b0;
        vyn_d  = 1'b1;
        anim_d = '0;
        adiv_d = '0;
        cnt_d  = '0;
        st_d   = S_FLY;
      end
      S_FLY: begin
        // A hit freezes the duck even if a tick lands in the same cycle.
        if (hit_in) begin
          hit_d = 1'b1;
          cnt_d = '0;
          st_d  = S_SHOT;
        end else if (tick_q) begin
          anim_step = 1'b1;
          if (nx <= 12'sd0)                          begin x_d = '0;    vxn_d = 1'b0; end
          else if (nx >= $signed({2'b00, X_MAX}))    begin x_d = X_MAX; vxn_d = 1'b1; end
          else                                             x_d = nx[9:0];
          if (ny <= 12'sd0)                          begin y_d = '0;    vyn_d = 1'b0; end
          else if (ny >= $signed({2'b00, Y_MAX}))    begin y_d = Y_MAX; vyn_d = 1'b1; end
          else                                             y_d = ny[9:0];
`ifdef DUCK_ESCAPE_EN
          if (cnt_q == 16'(FLY_TICKS - 1)) begin
            cnt_d = '0;
            st_d  = S_ESCAPE;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
`endif
        end
      end
      S_SHOT: if (tick_q) begin
        if (cnt_q == 16'(SHOT_TICKS - 1)) begin
          cnt_d = '0;
          st_d  = S_FALL;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_FALL: if (tick_q) begin
        if (y4 >= {1'b0, Y_MAX}) begin
          y_d  = Y_MAX;
          st_d = S_SPAWN;
        end else begin
          y_d   = y4[9:0];
          cnt_d = cnt_q + 16'd1;
        end
      end
`ifdef DUCK_ESCAPE_EN
      S_ESCAPE: if (tick_q) begin
        if (y_q < 10'd4) begin
          esc_d = 1'b1;
          st_d  = S_SPAWN;
        end else begin
          y_d       = y_q - 10'd4;
          anim_step = 1'b1;
        end
      end
`endif
      default: st_d = S_IDLE;
    endcase

    if (anim_step) begin
      if (adiv_q == 3'd5) begin
        adiv_d = '0;
        anim_d = anim_q + 2'd1;
      end else begin
        adiv_d = adiv_q + 3'd1;
      end
    end

    // Game leaving the active states overrides everything, pulses included.
    if (!active) begin
      st_d  = S_IDLE;
      hit_d = 1'b0;
`ifdef DUCK_ESCAPE_EN
      esc_d = 1'b0;
`endif
    end
  end

  // Sprite frame: fly frames 0-3 (right) / 4-7 (left), 8 shot, 9/10 falling.
  always_comb begin
    case (st_q)
      S_SHOT:  frame = 4'd8;
      S_FALL:  frame = cnt_q[3] ? 4'd10 : 4'd9;
      default: frame = {1'b0, vxn_q, anim_q};
    endcase
  end

  // Unsigned wrap makes pixels left of / above the box look huge, so a single
  // < 64 compare per axis bounds the box on both sides.
  always_comb begin
    dx        = DrawX - x_q;
    dy        = DrawY - y_q;
    is_duck_d = active && (st_q != S_IDLE) && (st_q != S_SPAWN) &&
                (dx < 10'd64) && (dy < 10'd64);
    addr_d    = is_duck_d ? {frame, dy[5:0], dx[5:0]} : 16'd0;
  end

  assign is_duck   = is_duck_q;
  assign duck_addr = addr_q;
  assign duck_hit  = hit_q;
`ifdef DUCK_ESCAPE_EN
  assign duck_escaped = esc_q;
`else
  assign duck_escaped = 1'b0;
`endif

endmodule

// File: tb/tb_duck_sprite_ctrl.sv
// Directed bench for duck_sprite_ctrl: spawn/fly, wall clamp, hit/shot/fall,
// hit-box edges, state drop, escape (or its absence), async reset mid-fall.
module tb_duck_sprite_ctrl;
  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        frame_clk = 1'b0;
  logic [2:0]  state = 3'b000;
  logic [9:0]  DrawX = '0, DrawY = '0;
  logic        shot_valid = 1'b0;
  logic [9:0]  shot_x = '0, shot_y = '0;
  logic        is_duck;
  logic [15:0] duck_addr;
  logic        duck_hit, duck_escaped;

  int n_chk = 0;
  int n_bad = 0;
  int hit_cnt = 0;
  int esc_cnt = 0;

  duck_sprite_ctrl dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .state(state),
    .DrawX(DrawX), .DrawY(DrawY), .shot_valid(shot_valid),
    .shot_x(shot_x), .shot_y(shot_y), .is_duck(is_duck),
    .duck_addr(duck_addr), .duck_hit(duck_hit), .duck_escaped(duck_escaped)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    if (duck_hit === 1'b1)     hit_cnt <= hit_cnt + 1;
    if (duck_escaped === 1'b1) esc_cnt <= esc_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One frame tick; optionally a shot lined up with the cycle the tick is used.
  task automatic do_tick(input bit sh, input logic [9:0] sx, input logic [9:0] sy,
                         input bit exp_hit);
    @(negedge Clk) frame_clk = 1'b1;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    if (sh) begin shot_valid = 1'b1; shot_x = sx; shot_y = sy; end
    @(negedge Clk);
    shot_valid = 1'b0;
    frame_clk  = 1'b0;
    if (sh) begin
      chk("tick_shot_hit", {31'd0, duck_hit}, {31'd0, exp_hit});
      @(negedge Clk);
      chk("hit_one_cycle", {31'd0, duck_hit}, 32'd0);
    end
    repeat (3) @(negedge Clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) do_tick(1'b0, '0, '0, 1'b0);
  endtask

  task automatic shoot(input string tag, input logic [9:0] sx, input logic [9:0] sy,
                       input bit exp_hit);
    @(negedge Clk) begin shot_valid = 1'b1; shot_x = sx; shot_y = sy; end
    @(negedge Clk) shot_valid = 1'b0;
    chk(tag, {31'd0, duck_hit}, {31'd0, exp_hit});
    @(negedge Clk);
  endtask

  task automatic probe(input string tag, input logic [9:0] px, input logic [9:0] py,
                       input bit exp_in, input logic [15:0] exp_addr);
    @(negedge Clk) begin DrawX = px; DrawY = py; end
    @(negedge Clk);
    chk({tag, "_in"},   {31'd0, is_duck}, {31'd0, exp_in});
    chk({tag, "_addr"}, {16'd0, duck_addr}, {16'd0, exp_addr});
  endtask

  initial begin
    #12;
    chk("rst_is_duck", {31'd0, is_duck}, 32'd0);
    chk("rst_addr",    {16'd0, duck_addr}, 32'd0);
    chk("rst_hit",     {31'd0, duck_hit}, 32'd0);
    chk("rst_esc",     {31'd0, duck_escaped}, 32'd0);
    @(negedge Clk) Reset_n = 1'b1;
    probe("idle", 10'd288, 10'd416, 1'b0, 16'h0000);

    // Spawn and first tick
    state = 3'b001;
    repeat (3) @(negedge Clk);
    probe("spawn", 10'd288, 10'd416, 1'b1, 16'h0000);
    ticks(1);
    probe("tick1", 10'd300, 10'd420, 1'b1, {4'd0, 6'd6, 6'd10});
    probe("tick1_left", 10'd289, 10'd414, 1'b0, 16'h0000);

    // 144 ticks total: x clamps at 576 moving left, y = 128, frame 4
    ticks(143);
    probe("clamp", 10'd576, 10'd128, 1'b1, 16'h4000);
    probe("clamp_x_minus1", 10'd575, 10'd128, 1'b0, 16'h0000);

    // Bottom-right corner shot on a tick: hit wins, no motion, frame 8
    do_tick(1'b1, 10'd639, 10'd191, 1'b1);
    probe("shot_pos", 10'd576, 10'd128, 1'b1, 16'h8000);
    probe("shot_corner", 10'd639, 10'd191, 1'b1, 16'h8FFF);
    do_tick(1'b1, 10'd600, 10'd150, 1'b0);
    chk("no_second_hit", hit_cnt, 1);
    ticks(28);
    probe("shot_29", 10'd576, 10'd128, 1'b1, 16'h8000);
    ticks(1);
    probe("fall_start", 10'd576, 10'd128, 1'b1, 16'h9000);
    ticks(8);
    probe("fall_8", 10'd576, 10'd160, 1'b1, 16'hA000);
    ticks(63);
    probe("fall_71", 10'd576, 10'd412, 1'b1, 16'h9000);
    ticks(1);
    probe("respawn", 10'd288, 10'd416, 1'b1, 16'h0000);

    // Hit-box edges at x=288, y=416
    shoot("miss_x64",   10'd352, 10'd416, 1'b0);
    shoot("miss_y64",   10'd288, 10'd480, 1'b0);
    shoot("miss_xm1",   10'd287, 10'd416, 1'b0);
    shoot("hit_corner", 10'd288, 10'd416, 1'b1);
    chk("hit_count", hit_cnt, 2);

    // Dropping state during SHOT: outputs clear in one cycle, no pulse
    @(negedge Clk) begin DrawX = 10'd288; DrawY = 10'd416; state = 3'b011; end
    @(negedge Clk);
    chk("drop_is_duck", {31'd0, is_duck}, 32'd0);
    chk("drop_addr",    {16'd0, duck_addr}, 32'd0);
    chk("drop_hit",     {31'd0, duck_hit}, 32'd0);
    state = 3'b100;
    repeat (3) @(negedge Clk);
    probe("reactivate", 10'd288, 10'd416, 1'b1, 16'h0000);

`ifdef DUCK_ESCAPE_EN
    ticks(900);
    chk("escape_once", esc_cnt, 1);
`else
    ticks(2000);
    chk("no_escape", esc_cnt, 0);
`endif
    chk("hit_count_final", hit_cnt, 2);

    // Async reset in the middle of FALL
    @(negedge Clk) Reset_n = 1'b0;
    @(negedge Clk) Reset_n = 1'b1;
    repeat (3) @(negedge Clk);
    ticks(10);
    shoot("hit_for_fall", 10'd308, 10'd396, 1'b1);
    ticks(31);
    probe("mid_fall", 10'd308, 10'd400, 1'b1, 16'h9000);
    #2 Reset_n = 1'b0;
    #1;
    chk("arst_is_duck", {31'd0, is_duck}, 32'd0);
    chk("arst_addr",    {16'd0, duck_addr}, 32'd0);
    probe("arst_hold", 10'd308, 10'd400, 1'b0, 16'h0000);
    chk("arst_esc", {31'd0, duck_escaped}, 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: sim time exceeded limit");
    $fatal(1);
  end
endmodule
